// File: rtl/max_unpooling_2_if.sv
// Stream bundle for the 2x2 max-unpooling block: pooled input stream and unpooled output stream.
interface max_unpooling_2_if #(
  parameter int unsigned bitwidth = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [bitwidth-1:0] in_data;
  logic [1:0]                 in_idx;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [bitwidth-1:0] out_data;
  logic                       out_last;

  // Environment side: produces pooled elements, consumes unpooled elements.
  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Block side.
  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/max_unpooling_2.sv
// Streaming 2x2 max-unpooling: buffers one pooled row with its argmax positions, then emits the
// top and bottom full-resolution rows, placing each value at its argmax and zero elsewhere.
module max_unpooling_2 #(
  parameter int unsigned bitwidth = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned IN_DIM   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  max_unpooling_2_if.slave bus
);

  localparam int unsigned JW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int unsigned CW = $clog2(2 * IN_DIM);
  localparam int unsigned HW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [JW-1:0] JLast = JW'(IN_DIM - 1);
  localparam logic [CW-1:0] CLast = CW'(2 * IN_DIM - 1);
  localparam logic [HW-1:0] HLast = HW'(CHANNELS - 1);

  typedef enum logic [1:0] {StFill, StEmitTop, StEmitBot} state_e;

  state_e                     state_q, state_d;
  logic [JW-1:0]              j_q, j_d;
  logic [JW-1:0]              i_q, i_d;
  logic [CW-1:0]              c_q, c_d;
  logic [HW-1:0]              ch_q, ch_d;
  logic signed [bitwidth-1:0] buf_val_q [IN_DIM];
  logic [1:0]                 buf_idx_q [IN_DIM];

  logic                       buf_we;
  logic [JW-1:0]              sel;
  logic                       hit;
  logic                       in_ready;
  logic                       out_valid;
  logic                       out_last;
  logic signed [bitwidth-1:0] out_data;

  // Window under the output column; its stored argmax must match {col offset, row offset}.
  always_comb begin
    sel = JW'(c_q >> 1);
    hit = (buf_idx_q[sel] == {c_q[0], state_q == StEmitBot});
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    i_d       = i_q;
    c_d       = c_q;
    ch_d      = ch_q;
    buf_we    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    unique case (state_q)
      StFill: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          buf_we = 1'b1;
          if (j_q == JLast) begin
            j_d     = '0;
            c_d     = '0;
            state_d = StEmitTop;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      StEmitTop, StEmitBot: begin
        out_valid = 1'b1;
        out_data  = hit ? buf_val_q[sel] : '0;
        out_last  = (state_q == StEmitBot) && (c_q == CLast) && (i_q == JLast) && (ch_q == HLast);
        if (bus.out_ready) begin
          if (c_q == CLast) begin
            c_d = '0;
            if (state_q == StEmitTop) begin
              state_d = StEmitBot;
            end else begin
              state_d = StFill;
              j_d     = '0;
              if (i_q == JLast) begin
                i_d  = '0;
                ch_d = (ch_q == HLast) ? '0 : ch_q + HW'(1);
              end else begin
                i_d = i_q + JW'(1);
              end
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;

  // State and position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      j_q     <= '0;
      i_q     <= '0;
      c_q     <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      c_q     <= c_d;
      ch_q    <= ch_d;
    end
  end

  // Pooled-row buffer, written at slot j on each accepted element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(IN_DIM); k++) begin
        buf_val_q[k] <= '0;
        buf_idx_q[k] <= '0;
      end
    end else if (buf_we) begin
      buf_val_q[j_q] <= bus.in_data;
      buf_idx_q[j_q] <= bus.in_idx;
    end
  end

endmodule

// File: tb/tb_max_unpooling_2.sv
// Directed bench for max_unpooling_2: hand-computed rows, a full frame against a placement
// model, output backpressure, and asynchronous reset in the middle of a bottom row.
module tb_max_unpooling_2;

  typedef logic signed [31:0] vrow_t [5];
  typedef logic [1:0]         xrow_t [5];
  typedef logic signed [31:0] orow_t [20];

  logic clk;
  logic rst_n;
  bit   bp_en;
  int   n_vec;
  int   n_err;

  logic signed [31:0] got_d [$];
  bit                 got_l [$];
  logic signed [31:0] exp_d [$];
  bit                 exp_l [$];

  bit                 prev_stall;
  logic signed [31:0] prev_d;
  logic               prev_l;

  max_unpooling_2_if #(.bitwidth(32)) bus ();

  max_unpooling_2 #(
    .bitwidth(32),
    .CHANNELS(2),
    .IN_DIM  (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor at mid-cycle: records transfers, checks stall stability and input blocking.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall valid", bus.out_valid, 1);
        check("stall data", bus.out_data, prev_d);
        check("stall last", bus.out_last, prev_l);
      end
      if (bus.out_valid) check("in_ready in emit", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = bus.out_data;
      prev_l     = bus.out_last;
    end
  end

  // Downstream ready: always high, or pseudo-random when backpressure is enabled.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Presents a row element by element; leaves in_valid high after the last accept.
  task automatic send_row(input vrow_t v, input xrow_t x);
    for (int k = 0; k < 5; k++) begin
      bit acc = 1'b0;
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = v[k];
      bus.in_idx   = x[k];
      while (!acc && n < 2000) begin
        @(negedge clk);
        if (bus.in_ready) acc = 1'b1;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) check("accept timeout", 0, 1);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Placement model: each pooled value lands at (row offset, 2j + col offset) of a zero grid.
  task automatic add_exp(input vrow_t v, input xrow_t x, input bit final_row);
    logic signed [31:0] grid [2][10];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 10; c++) grid[r][c] = '0;
    for (int j = 0; j < 5; j++) grid[x[j][0]][2 * j + int'(x[j][1])] = v[j];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 10; c++) begin
        exp_d.push_back(grid[r][c]);
        exp_l.push_back(final_row && r == 1 && c == 9);
      end
  endtask

  task automatic add_const(input orow_t o);
    for (int k = 0; k < 20; k++) begin
      exp_d.push_back(o[k]);
      exp_l.push_back(1'b0);
    end
  endtask

  task automatic clear_q();
    got_d.delete();
    got_l.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic compare_outputs(input string tag);
    int n = 0;
    int m;
    while (got_d.size() < exp_d.size() && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, " count"}, got_d.size(), exp_d.size());
    m = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s data[%0d]", tag, k), got_d[k], exp_d[k]);
      check($sformatf("%s last[%0d]", tag, k), got_l[k], exp_l[k]);
    end
    clear_q();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_q();
  endtask

  initial begin
    vrow_t v2 = '{1, 2, 3, 4, 5};
    xrow_t x2 = '{0, 0, 0, 0, 0};
    orow_t o2 = '{1, 0, 2, 0, 3, 0, 4, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vrow_t v3 = '{-7, 8, -9, 10, 11};
    xrow_t x3 = '{3, 2, 1, 0, 1};
    orow_t o3 = '{0, 0, 0, 8, 0, 0, 10, 0, 0, 0, 0, -7, 0, 0, -9, 0, 0, 0, 11, 0};
    vrow_t vr;
    xrow_t xr;
    int    n;

    n_vec        = 0;
    n_err        = 0;
    bp_en        = 1'b0;
    prev_stall   = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_idx   = '0;

    // 1: reset state, and nothing emitted without input
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_last", bus.out_last, 0);
    check("rst out_data", bus.out_data, 0);
    repeat (10) @(posedge clk);
    #1;
    check("idle out_valid", bus.out_valid, 0);
    check("idle outputs", got_d.size(), 0);

    // 2: idx 0 row; out_valid the cycle after the fifth accept
    add_const(o2);
    send_row(v2, x2);
    check("latency out_valid", bus.out_valid, 1);
    idle();
    compare_outputs("row idx0");

    // 3: mixed argmax with negative values
    add_const(o3);
    send_row(v3, x3);
    idle();
    compare_outputs("row mixed");

    // 4: full frame from element (0,0,0)
    do_reset();
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          vr[j] = $urandom;
          xr[j] = 2'($urandom_range(0, 3));
        end
        add_exp(vr, xr, ch == 1 && i == 4);
        send_row(vr, xr);
      end
    idle();
    compare_outputs("frame");

    // 5: next frame under backpressure, in_valid held high across the emit phase
    bp_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 5; j++) begin
        vr[j] = $urandom;
        xr[j] = 2'($urandom_range(0, 3));
      end
      add_exp(vr, xr, 1'b0);
      send_row(vr, xr);
    end
    idle();
    compare_outputs("backpressure");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 6: asynchronous reset at bottom-row column 4
    send_row(v2, x2);
    idle();
    n = 0;
    while (got_d.size() < 14 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach bottom c4", got_d.size(), 14);
    @(posedge clk);
    #2;
    check("pre-reset out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async out_valid", bus.out_valid, 0);
    check("async in_ready", bus.in_ready, 1);
    check("async out_data", bus.out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_q();
    add_const(o2);
    send_row(v2, x2);
    idle();
    compare_outputs("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
